// File: rtl/uart_tx_byte_pkg.sv
// uart_tx_byte_pkg: shared UART definitions (FSM encodings, default baud divisor)
//   for the transmitter and the future receiver.
package uart_tx_byte_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_byte_if.sv
// uart_tx_byte_if: byte-wide valid/ready handshake into the UART transmitter.
//   tx_data  [7:0] byte offered by the producer
//   tx_valid       producer has a byte on tx_data
//   tx_ready       transmitter accepts a byte this cycle
interface uart_tx_byte_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_byte_baud_tick_gen.sv
// baud_tick_gen: free-running 0..CLKS_PER_BIT-1 counter, tick on the last count.
//   clk, rst_n  clock, synchronous active-low reset
//   clear       restart the count at 0 on the next edge (phase-aligns a frame)
//   tick        high on the last clock of each bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    logic [CNT_W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 UART transmitter, one byte per valid/ready handshake, LSB first.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         slave side of the byte handshake (tx_data, tx_valid, tx_ready)
//   tx          registered serial line, idle high
//   busy        frame in progress (START, DATA or STOP)
module uart_tx_byte
    import uart_tx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_byte_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_param
        $error("uart_tx_byte: CLKS_PER_BIT must be >= 2 and STOP_BITS 1 or 2");
    end
    state_t     state, state_nx;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       bit_end, accept, tx_nx, last_stop;
    assign accept    = bus.tx_valid & bus.tx_ready;
    // bit_idx is reused as the stop-bit counter; it has wrapped to 0 on leaving DATA
    assign last_stop = bit_idx == 3'(STOP_BITS - 1);
    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (bit_end)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_nx;
            tx    <= tx_nx;
            if (accept) shift <= bus.tx_data;
            else if (state == DATA && bit_end) shift <= shift >> 1;
            if (bit_end && state == DATA) bit_idx <= bit_idx + 3'd1;
            else if (bit_end && state == STOP) bit_idx <= last_stop ? 3'd0 : bit_idx + 3'd1;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? START : IDLE;
            START: state_nx = bit_end ? DATA : START;
            DATA:  state_nx = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:  state_nx = (bit_end && last_stop) ? IDLE : STOP;
        endcase
    end
    // tx is registered from the next state; within DATA the next bit is shift[1]
    // because the shift register moves on the same edge
    always_comb begin
        tx_nx        = state_nx == START ? 1'b0 :
                       state_nx == DATA  ? ((state == DATA && bit_end) ? shift[1] : shift[0]) :
                       1'b1;
        busy         = state != IDLE;
        bus.tx_ready = (state == IDLE) & rst_n;
    end
endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: directed self-checking bench for uart_tx_byte.
module tb_uart_tx_byte;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, tx2, busy2;
    int total = 0;
    int bad = 0;
    uart_tx_byte_if bus ();
    uart_tx_byte_if bus2 ();
    always #5 clk = ~clk;
    uart_tx_byte #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .tx(tx), .busy(busy)
    );
    uart_tx_byte #(.CLKS_PER_BIT(868), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .tx(tx2), .busy(busy2)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Expects tx_valid high with tx_ready high in the current cycle: the next edge accepts.
    task automatic frame(input logic [7:0] b, input bit drop, input logic [7:0] mid);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0 && drop) bus.tx_valid = 1'b0;
            if (i == 20) bus.tx_data = mid;
            chk($sformatf("tx_%02h_c%0d", b, i), 32'(tx), 32'(f[i/4]));
            chk($sformatf("busy_%02h_c%0d", b, i), 32'(busy), 32'd1);
            if (i % 4 == 0) chk($sformatf("ready_%02h_c%0d", b, i), 32'(bus.tx_ready), 32'd0);
        end
        tick();
        chk("end_tx", 32'(tx), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(bus.tx_ready), 32'd1);
    endtask
    initial begin
        int n;
        logic [10:0] got;
        bus.tx_data   = 8'hA5;
        bus.tx_valid  = 1'b1;
        bus2.tx_data  = 8'h00;
        bus2.tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(bus.tx_ready), 32'd0);
            chk("rst_tx2", 32'(tx2), 32'd1);
        end
        rst_n = 1'b1;
        #1;
        chk("release_ready", 32'(bus.tx_ready), 32'd1);
        frame(8'hA5, 1'b1, 8'hA5);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        frame(8'h00, 1'b0, 8'hFF);
        frame(8'hFF, 1'b1, 8'hFF);
        bus.tx_data  = 8'h81;
        bus.tx_valid = 1'b1;
        frame(8'h81, 1'b1, 8'h3C);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        chk("abort_start", 32'(tx), 32'd0);
        repeat (17) tick();
        chk("abort_bit3", 32'(tx), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_ready", 32'(bus.tx_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_release_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = 8'h0F;
        bus.tx_valid = 1'b1;
        frame(8'h0F, 1'b1, 8'h0F);
        bus2.tx_data  = 8'h41;
        bus2.tx_valid = 1'b1;
        tick();
        bus2.tx_valid = 1'b0;
        n   = 0;
        got = '0;
        while (busy2 && n < 12000) begin
            if (n % 868 == 434 && n < 9548) got[n/868] = tx2;
            n++;
            tick();
        end
        chk("uart_frame_len", 32'(n), 32'd9548);
        chk("uart_start", 32'(got[0]), 32'd0);
        chk("uart_byte", 32'(got[8:1]), 32'h41);
        chk("uart_stop", 32'(got[10:9]), 32'd3);
        chk("uart_idle_tx", 32'(tx2), 32'd1);
        chk("uart_idle_ready", 32'(bus2.tx_ready), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
